// File: rtl/sdram_req_scheduler.sv
// rtl/sdram_req_scheduler.sv - two-master Wishbone scheduler serialising requests into the SDRAM controller
module sdram_req_scheduler #(
  parameter logic [7:0] REGION   = 8'h38,
  parameter int         MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_adr_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_adr_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic [22:0] ctrl_addr,
  output logic        ctrl_rw,
  output logic [31:0] ctrl_data_in,
  output logic [3:0]  ctrl_mask,
  output logic        ctrl_in_valid,
  input  logic        ctrl_busy,
  input  logic        ctrl_out_valid,
  input  logic [31:0] ctrl_data_out,
  output logic [1:0]  grant,
  output logic        sched_busy
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_ACK} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    grant_q, grant_d;
  logic [22:0]   addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    mask_q, mask_d;
  logic          in_valid_q, in_valid_d;
  logic [31:0]   rdata_q, rdata_d;

  logic req0, req1, pick1, hold_full;
  logic unused_adr_bits;

  assign req0      = m0_stb_i & m0_cyc_i & (m0_adr_i[31:24] == REGION);
  assign req1      = m1_stb_i & m1_cyc_i & (m1_adr_i[31:24] == REGION);
  assign hold_full = (hold_q == HW'(MAX_HOLD));
  // DMA wins when alone, or when the CPU has used up its consecutive-grant allowance.
  assign pick1     = req1 & (~req0 | hold_full);
  assign unused_adr_bits = &{1'b0, m0_adr_i[23], m1_adr_i[23]};

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    in_valid_d = in_valid_q;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          if (pick1) begin
            addr_d  = m1_adr_i[22:0];
            rw_d    = m1_we_i;
            wdata_d = m1_dat_i;
            mask_d  = m1_sel_i & {4{m1_we_i}};
            grant_d = 2'b10;
            hold_d  = '0;
          end else begin
            addr_d  = m0_adr_i[22:0];
            rw_d    = m0_we_i;
            wdata_d = m0_dat_i;
            mask_d  = m0_sel_i & {4{m0_we_i}};
            grant_d = 2'b01;
            hold_d  = req1 ? (hold_full ? hold_q : hold_q + HW'(1)) : '0;
          end
          in_valid_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (~ctrl_busy) begin
          in_valid_d = 1'b0;
          state_d    = rw_q ? S_ACK : S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (ctrl_out_valid) begin
          rdata_d = ctrl_data_out;
          state_d = S_ACK;
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      grant_q    <= 2'b00;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      mask_q     <= '0;
      in_valid_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      in_valid_q <= in_valid_d;
      rdata_q    <= rdata_d;
    end
  end

  // A master that dropped its cycle before the ack is not acked; the transfer itself still completed.
  assign m0_ack_o      = (state_q == S_ACK) & grant_q[0] & m0_stb_i & m0_cyc_i;
  assign m1_ack_o      = (state_q == S_ACK) & grant_q[1] & m1_stb_i & m1_cyc_i;
  assign m0_dat_o      = rdata_q;
  assign m1_dat_o      = rdata_q;
  assign ctrl_addr     = addr_q;
  assign ctrl_rw       = rw_q;
  assign ctrl_data_in  = wdata_q;
  assign ctrl_mask     = mask_q;
  assign ctrl_in_valid = in_valid_q;
  assign grant         = grant_q;
  assign sched_busy    = (state_q != S_IDLE);

endmodule
